frame_buffer_ctrl: RTL and testbench

- Sequences and owns the single-port SP256K frame buffer between the camera capture path (writer) and the SPI readout path (reader).
- Runs a per-frame ownership state machine: capture writes the frame; the MCU then reads it out over SPI; the MCU then releases it.
- Sits in the sys_clk domain between the pixel packer / capture synchronizer and the SPI slave.
- Its buffer_ready output feeds the status LEDs.

---
 rtl/frame_buffer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// Purpose: per-frame ownership sequencer for the single-port SP256K frame buffer (capture writes, SPI reads, MCU releases).
// Latency: wr_ack 1 cycle after wr_req; rd_ack 1 cycle and rd_valid 2 cycles after rd_req; one access per cycle.
// Backpressure: none; requests not legal for the current owner are dropped without ack.
// Ports: sys_clk/nreset; frame_start/frame_end/rd_done control pulses; wr_* capture port; rd_* readout port;
//        ram_* SP256K interface; buffer_ready/state/overrun/drop_cnt status.
module frame_buffer_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 4800
) (
  input  logic              sys_clk,
  input  logic              nreset,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_we,
  output logic [3:0]        ram_maskwe,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_do,
  output logic              buffer_ready,
  output logic [1:0]        state,
  output logic              overrun,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  // One extra bit so the limit compare cannot wrap for any address width.
  localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(FRAME_WORDS);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ram_ad, w_ram_ad_nxt;
  logic [DATA_W-1:0]   r_ram_di, w_ram_di_nxt;
  logic                r_ram_we, w_ram_we_nxt;
  logic                r_ram_cs, w_ram_cs_nxt;
  logic [3:0]          r_ram_mask, w_ram_mask_nxt;
  logic                r_wr_ack, w_wr_ack_nxt;
  logic                r_rd_ack, w_rd_ack_nxt;
  logic                r_rd_oob, w_rd_oob_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic [7:0]          r_drop_cnt, w_drop_nxt;
  logic                r_rd_valid;
  logic                r_rd_oob_q;
  logic                w_rd_issue;
  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic [7:0]          w_drop_inc;

  assign w_wr_in_range = ({1'b0, wr_addr} < LP_LIMIT);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_LIMIT);
  assign w_drop_inc    = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_ram_ad_nxt   = r_ram_ad;
    w_ram_di_nxt   = r_ram_di;
    w_ram_we_nxt   = 1'b0;
    w_ram_cs_nxt   = 1'b0;
    w_ram_mask_nxt = 4'h0;
    w_wr_ack_nxt   = 1'b0;
    w_rd_ack_nxt   = 1'b0;
    w_rd_oob_nxt   = 1'b0;
    w_overrun_nxt  = r_overrun;
    w_drop_nxt     = r_drop_cnt;
    w_rd_issue     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A restart pulse needs no action: capture simply keeps going.
        if (wr_req) begin
          if (w_wr_in_range) begin
            w_ram_ad_nxt   = wr_addr;
            w_ram_di_nxt   = wr_data;
            w_ram_we_nxt   = 1'b1;
            w_ram_cs_nxt   = 1'b1;
            w_ram_mask_nxt = 4'hF;
            w_wr_ack_nxt   = 1'b1;
          end else begin
            w_overrun_nxt  = 1'b1;
          end
        end
        if (frame_end) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (frame_start) w_drop_nxt = w_drop_inc;
        // The first read both claims the buffer and is served.
        if (rd_req) begin
          w_rd_issue  = 1'b1;
          w_state_nxt = S_READOUT;
        end
      end
      S_READOUT: begin
        if (frame_start) w_drop_nxt = w_drop_inc;
        if (rd_done)     w_state_nxt = S_IDLE;
        else if (rd_req) w_rd_issue  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Out-of-range reads are still acked and delivered, but as zero data.
    if (w_rd_issue) begin
      w_ram_ad_nxt = rd_addr;
      w_ram_cs_nxt = 1'b1;
      w_rd_ack_nxt = 1'b1;
      w_rd_oob_nxt = !w_rd_in_range;
      if (!w_rd_in_range) w_overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_ram_ad   <= '0;
      r_ram_di   <= '0;
      r_ram_we   <= 1'b0;
      r_ram_cs   <= 1'b0;
      r_ram_mask <= 4'h0;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_oob_q <= 1'b0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ram_ad   <= w_ram_ad_nxt;
      r_ram_di   <= w_ram_di_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_cs   <= w_ram_cs_nxt;
      r_ram_mask <= w_ram_mask_nxt;
      r_wr_ack   <= w_wr_ack_nxt;
      r_rd_ack   <= w_rd_ack_nxt;
      r_rd_oob   <= w_rd_oob_nxt;
      // SPRAM samples the address on the edge after rd_ack; its data is ready one edge later.
      r_rd_valid <= r_rd_ack;
      r_rd_oob_q <= r_rd_oob;
      r_overrun  <= w_overrun_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // ram_do is already registered inside the SPRAM, so it is passed through, gated by the valid pipeline.
  assign rd_data      = (r_rd_valid && !r_rd_oob_q) ? ram_do : '0;
  assign rd_valid     = r_rd_valid;
  assign rd_ack       = r_rd_ack;
  assign wr_ack       = r_wr_ack;
  assign ram_ad       = r_ram_ad;
  assign ram_di       = r_ram_di;
  assign ram_we       = r_ram_we;
  assign ram_cs       = r_ram_cs;
  assign ram_maskwe   = r_ram_mask;
  assign buffer_ready = (r_state == S_READY) || (r_state == S_READOUT);
  assign state        = r_state;
  assign overrun      = r_overrun;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Purpose: self-checking bench for frame_buffer_ctrl with an SPRAM model and a frame-level reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_frame_buffer_ctrl;

  logic        sys_clk;
  logic        nreset;
  logic        frame_start, frame_end;
  logic        wr_req;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic        rd_done;
  logic [13:0] ram_ad;
  logic [15:0] ram_di;
  logic        ram_we;
  logic [3:0]  ram_maskwe;
  logic        ram_cs;
  logic [15:0] ram_do;
  logic        buffer_ready;
  logic [1:0]  state;
  logic        overrun;
  logic [7:0]  drop_cnt;

  frame_buffer_ctrl dut (
    .sys_clk(sys_clk), .nreset(nreset),
    .frame_start(frame_start), .frame_end(frame_end),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_done(rd_done),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_we(ram_we), .ram_maskwe(ram_maskwe),
    .ram_cs(ram_cs), .ram_do(ram_do),
    .buffer_ready(buffer_ready), .state(state), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // SP256K behaviour: registered read data, full-word writes.
  logic [15:0] mem [0:16383];
  always @(posedge sys_clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_ad] <= ram_di;
      else        ram_do      <= mem[ram_ad];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the frame, what the frame holds, and which read results are due when.
  typedef struct { int due; logic [15:0] data; } rdexp_t;
  rdexp_t      rdq[$];
  logic [15:0] fb [0:16383];
  int          m_state;
  int          m_drop;
  logic        m_ovr;
  logic [13:0] m_ad;
  logic [15:0] m_di, m_rd_data;
  logic        m_wr_ack, m_rd_ack, m_we, m_cs, m_rd_valid;
  logic [3:0]  m_mask;
  logic [15:0] got[$];
  int          wr_acks, we_pulses;

  task automatic model_edge();
    int k;
    bit go_rd;
    k = cyc_n + 1;
    go_rd = 0;
    m_wr_ack = 0; m_rd_ack = 0; m_we = 0; m_cs = 0; m_mask = 4'h0;
    m_rd_valid = 0; m_rd_data = 16'h0;
    if (!nreset) begin
      m_state = 0; m_drop = 0; m_ovr = 0; m_ad = '0; m_di = '0;
      rdq.delete();
    end else begin
      if (rdq.size() > 0 && rdq[0].due == k) begin
        m_rd_valid = 1;
        m_rd_data  = rdq[0].data;
        void'(rdq.pop_front());
      end
      case (m_state)
        0: if (frame_start) m_state = 1;
        1: begin
          if (wr_req) begin
            if (int'(wr_addr) < 4800) begin
              fb[wr_addr] = wr_data;
              m_we = 1; m_cs = 1; m_mask = 4'hF; m_wr_ack = 1;
              m_ad = wr_addr; m_di = wr_data;
            end else m_ovr = 1;
          end
          if (frame_end) m_state = 2;
        end
        2: begin
          if (frame_start && m_drop < 255) m_drop++;
          if (rd_req) begin go_rd = 1; m_state = 3; end
        end
        default: begin
          if (frame_start && m_drop < 255) m_drop++;
          if (rd_done) m_state = 0;
          else if (rd_req) go_rd = 1;
        end
      endcase
      if (go_rd) begin
        m_ad = rd_addr; m_cs = 1; m_rd_ack = 1;
        rdq.push_back('{k + 1, (int'(rd_addr) < 4800) ? fb[rd_addr] : 16'h0});
        if (int'(rd_addr) >= 4800) m_ovr = 1;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge sys_clk);
    #1;
    cyc_n++;
    chk("state", state, m_state);
    chk("buffer_ready", buffer_ready, (m_state == 2 || m_state == 3));
    chk("wr_ack", wr_ack, m_wr_ack);
    chk("rd_ack", rd_ack, m_rd_ack);
    chk("rd_valid", rd_valid, m_rd_valid);
    if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
    chk("ram_we", ram_we, m_we);
    chk("ram_cs", ram_cs, m_cs);
    chk("ram_maskwe", ram_maskwe, m_mask);
    chk("ram_ad", ram_ad, m_ad);
    chk("ram_di", ram_di, m_di);
    chk("overrun", overrun, m_ovr);
    chk("drop_cnt", drop_cnt, m_drop);
    if (rd_valid) got.push_back(rd_data);
    if (wr_ack) wr_acks++;
    if (ram_we) we_pulses++;
  endtask

  task automatic idle_inputs();
    frame_start = 0; frame_end = 0; wr_req = 0; rd_req = 0; rd_done = 0;
  endtask

  logic [15:0] pix [4];

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = 16'h0; fb[i] = 16'h0; end
    ram_do = 16'h0;
    pix[0] = 16'h3264; pix[1] = 16'hC832; pix[2] = 16'h28B4; pix[3] = 16'hB428;
    nreset = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle_inputs();

    // Reset state
    cyc(); cyc();
    nreset = 1;
    cyc();

    // Capture four words, frame_end coincident with the last write
    frame_start = 1; cyc(); frame_start = 0;
    wr_acks = 0; we_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_addr = 14'(i); wr_data = pix[i]; frame_end = (i == 3);
      cyc();
    end
    idle_inputs(); cyc();
    chk("wr_ack_count", wr_acks, 4);
    chk("we_pulse_count", we_pulses, 4);
    chk("ready_state", state, 2);
    chk("ready_buffer_ready", buffer_ready, 1);

    // Two drops in READY, then two back-to-back read passes with a drop in READOUT
    frame_start = 1; cyc(); frame_start = 0; cyc();
    frame_start = 1; cyc(); frame_start = 0;
    got.delete();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) begin
        rd_req = 1; rd_addr = 14'(i); frame_start = (j == 0 && i == 1);
        cyc();
      end
    end
    idle_inputs(); cyc(); cyc();
    chk("readout_state", state, 3);
    chk("drop_cnt_3", drop_cnt, 3);
    chk("read_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("read_pixel", got[i], pix[i % 4]);
    rd_done = 1; cyc(); rd_done = 0;
    chk("release_state", state, 0);
    chk("release_buffer_ready", buffer_ready, 0);

    // Randomized traffic against the model
    repeat (1500) begin
      frame_start = ($urandom_range(0, 99) < 2);
      frame_end   = ($urandom_range(0, 99) < 3);
      rd_done     = ($urandom_range(0, 99) < 3);
      wr_req      = ($urandom_range(0, 99) < 70);
      rd_req      = ($urandom_range(0, 99) < 60);
      wr_addr     = ($urandom_range(0, 19) == 0) ? 14'($urandom_range(4800, 16383)) : 14'($urandom_range(0, 63));
      rd_addr     = ($urandom_range(0, 19) == 0) ? 14'($urandom_range(4800, 16383)) : 14'($urandom_range(0, 63));
      wr_data     = 16'($urandom);
      cyc();
    end
    idle_inputs();
    nreset = 0; cyc(); nreset = 1; cyc();

    // Requests ignored outside their owner states
    rd_req = 1; rd_addr = 14'd0; wr_req = 1; wr_addr = 14'd5; wr_data = 16'h1111;
    cyc(); cyc();
    chk("idle_cs", ram_cs, 0);
    wr_req = 0; frame_start = 1; cyc(); frame_start = 0;
    cyc();
    chk("capture_rd_ack", rd_ack, 0);
    chk("capture_rd_cs", ram_cs, 0);
    rd_req = 0;

    // Out-of-range write
    wr_req = 1; wr_addr = 14'd4800; wr_data = 16'h1234; cyc();
    chk("oob_wr_we", ram_we, 0);
    chk("oob_wr_ack", wr_ack, 0);
    chk("oob_wr_overrun", overrun, 1);
    wr_addr = 14'd7; wr_data = 16'h5A5A; cyc();
    frame_start = 1; wr_addr = 14'd8; wr_data = 16'hA5A5; cyc();
    chk("restart_state", state, 1);
    wr_req = 0;
    frame_end = 1; cyc(); frame_start = 0; frame_end = 0;
    chk("fs_fe_state", state, 2);
    wr_req = 1; wr_addr = 14'd9; cyc();
    chk("ready_wr_ack", wr_ack, 0);
    wr_req = 0;

    // Out-of-range read
    rd_req = 1; rd_addr = 14'd5000; cyc(); rd_req = 0;
    chk("oob_rd_ack", rd_ack, 1);
    wr_req = 1; cyc(); wr_req = 0;
    chk("oob_rd_valid", rd_valid, 1);
    chk("oob_rd_data", rd_data, 0);
    chk("readout_wr_ack", wr_ack, 0);

    // Drop counter saturation
    repeat (300) begin frame_start = 1; cyc(); frame_start = 0; cyc(); end
    chk("drop_sat", drop_cnt, 255);

    // rd_done coincident with rd_req: only the in-flight read completes
    rd_req = 1; rd_addr = 14'd7; cyc();
    rd_addr = 14'd8; rd_done = 1; cyc();
    idle_inputs();
    chk("done_state", state, 0);
    chk("done_rd_ack", rd_ack, 0);
    chk("inflight_valid", rd_valid, 1);
    chk("inflight_data", rd_data, 16'h5A5A);
    cyc();
    chk("dropped_rd_valid", rd_valid, 0);

    // Asynchronous reset mid-capture with a write pending
    frame_start = 1; cyc(); frame_start = 0;
    wr_req = 1; wr_addr = 14'd3; wr_data = 16'hBEEF; cyc();
    #2 nreset = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_wr_ack", wr_ack, 0);
    chk("arst_ram_we", ram_we, 0);
    chk("arst_ram_cs", ram_cs, 0);
    chk("arst_ram_ad", ram_ad, 0);
    chk("arst_ram_di", ram_di, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_overrun", overrun, 0);
    cyc();
    nreset = 1; wr_req = 0;
    cyc(); cyc();
    chk("post_rst_wr_ack", wr_ack, 0);
    chk("post_rst_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
